// File: rtl/rip_lsu_align.sv
// rip_lsu_align: load/store access stage between execute and the data-memory port.
//   Accepts one byte/half/word/double access at a time and places it on a 64-bit
//   doubleword-addressed bus with byte strobes. Load data is aligned and then
//   sign- or zero-extended to D_WIDTH for writeback. Misaligned accesses return
//   a fault response and never touch memory.
// Ports:
//   clk, rstn                 clock, async active-low reset
//   req_*  (valid/ready)      access request from execute
//   mem_*  (valid/ready)      doubleword memory request
//   mem_rvalid/mem_rdata      memory response (load data or store ack)
//   resp_* (valid/ready)      result to writeback, including the misalign flag

package rip_lsu_pkg;
  localparam int B_WIDTH = 8;
  localparam int H_WIDTH = 16;
  localparam int W_WIDTH = 32;
  localparam int D_WIDTH = 64;
  localparam int NUM_LANES = D_WIDTH / B_WIDTH;

  typedef struct packed {
    logic       we;
    logic [1:0] size;
    logic       uns;
  } acc_t;
endpackage

// One byte lane of the store path: strobe and data byte for lane LANE given
// the byte offset and access size of the current request.
module rip_lsu_align_lane
  import rip_lsu_pkg::*;
#(
  parameter int LANE = 0
) (
  input  logic [2:0]         off,
  input  logic [1:0]         size,
  input  logic [D_WIDTH-1:0] wdata,
  output logic               strb,
  output logic [B_WIDTH-1:0] wbyte
);
  // diff = position of this lane inside the access; bit 3 set means the lane
  // lies below the access offset.
  logic [3:0] diff;

  always_comb begin
    diff  = 4'(LANE) - {1'b0, off};
    strb  = ~diff[3] & ({1'b0, diff[2:0]} < (4'd1 << size));
    wbyte = diff[3] ? '0 : wdata[{diff[2:0], 3'b000} +: B_WIDTH];
  end
endmodule

module rip_lsu_align
  import rip_lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int RD_WIDTH   = 5
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [1:0]             req_size,
  input  logic                   req_unsigned,
  input  logic [ADDR_WIDTH-1:0]  req_addr,
  input  logic [D_WIDTH-1:0]     req_wdata,
  input  logic [RD_WIDTH-1:0]    req_rd,
  output logic                   mem_valid,
  input  logic                   mem_ready,
  output logic                   mem_we,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic [NUM_LANES-1:0]   mem_wstrb,
  output logic [D_WIDTH-1:0]     mem_wdata,
  input  logic                   mem_rvalid,
  input  logic [D_WIDTH-1:0]     mem_rdata,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [D_WIDTH-1:0]     resp_data,
  output logic [RD_WIDTH-1:0]    resp_rd,
  output logic                   resp_we,
  output logic                   resp_misalign
);
  // One-hot so the handshake outputs come straight off a flop.
  typedef enum logic [3:0] {
    S_IDLE = 4'b0001,
    S_REQ  = 4'b0010,
    S_WAIT = 4'b0100,
    S_RESP = 4'b1000
  } state_t;

  state_t state, state_nxt;

  acc_t                          acc;
  logic [ADDR_WIDTH-1:0]         addr_q;
  logic [D_WIDTH-1:0]            wdata_q;
  logic [RD_WIDTH-1:0]           rd_q;
  logic                          misal;
  logic [D_WIDTH-1:0]            ld_shift, ld_ext;
  logic [NUM_LANES-1:0]          strb_l;
  logic [NUM_LANES-1:0][B_WIDTH-1:0] wdata_l;

  // Alignment check on the incoming request.
  always_comb begin
    unique case (req_size)
      2'd0:    misal = 1'b0;
      2'd1:    misal = req_addr[0];
      2'd2:    misal = |req_addr[1:0];
      default: misal = |req_addr[2:0];
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next state. A response is only registered in WAIT, so an rvalid in the
  // accept cycle or after a reset-abandoned access is dropped.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (req_valid)  state_nxt = misal ? S_RESP : S_REQ;
      S_REQ:   if (mem_ready)  state_nxt = S_WAIT;
      S_WAIT:  if (mem_rvalid) state_nxt = S_RESP;
      S_RESP:  if (resp_ready) state_nxt = S_IDLE;
      default:                 state_nxt = S_IDLE;
    endcase
  end

  // Request capture and response data.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc           <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      rd_q          <= '0;
      resp_data     <= '0;
      resp_misalign <= 1'b0;
    end else begin
      if (state == S_IDLE && req_valid) begin
        acc           <= '{we: req_we, size: req_size, uns: req_unsigned};
        addr_q        <= req_addr;
        wdata_q       <= req_wdata;
        rd_q          <= req_rd;
        resp_data     <= '0;
        resp_misalign <= misal;
      end
      if (state == S_WAIT && mem_rvalid)
        resp_data <= acc.we ? '0 : ld_ext;
    end
  end

  // Store path, one instance per byte lane.
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    rip_lsu_align_lane #(.LANE(l)) u_lane (
      .off   (addr_q[2:0]),
      .size  (acc.size),
      .wdata (wdata_q),
      .strb  (strb_l[l]),
      .wbyte (wdata_l[l])
    );
  end

  // Load path: bring the addressed bytes down to bit 0, then extend.
  always_comb begin
    ld_shift = mem_rdata >> {addr_q[2:0], 3'b000};
    unique case (acc.size)
      2'd0: ld_ext = {{(D_WIDTH-B_WIDTH){~acc.uns & ld_shift[B_WIDTH-1]}}, ld_shift[B_WIDTH-1:0]};
      2'd1: ld_ext = {{(D_WIDTH-H_WIDTH){~acc.uns & ld_shift[H_WIDTH-1]}}, ld_shift[H_WIDTH-1:0]};
      2'd2: ld_ext = {{(D_WIDTH-W_WIDTH){~acc.uns & ld_shift[W_WIDTH-1]}}, ld_shift[W_WIDTH-1:0]};
      default: ld_ext = ld_shift;
    endcase
  end

  // Outputs. Memory-side fields are zeroed outside REQ so the bus is quiet
  // when idle; inside REQ they come from captured state and stay stable.
  always_comb begin
    req_ready  = state[0];
    mem_valid  = state[1];
    resp_valid = state[3];
    mem_we     = mem_valid & acc.we;
    mem_addr   = mem_valid ? {addr_q[ADDR_WIDTH-1:3], 3'b000} : '0;
    mem_wstrb  = mem_valid ? strb_l : '0;
    mem_wdata  = mem_valid ? wdata_l : '0;
    resp_rd    = rd_q;
    resp_we    = acc.we;
  end
endmodule

// File: tb/tb_rip_lsu_align.sv
module tb_rip_lsu_align;
  logic        clk = 0, rstn = 0;
  logic        req_valid = 0, req_we = 0, req_unsigned = 0;
  logic [1:0]  req_size = 0;
  logic [31:0] req_addr = 0;
  logic [63:0] req_wdata = 0;
  logic [4:0]  req_rd = 0;
  logic        req_ready, mem_valid, mem_we;
  logic        mem_ready = 0, mem_rvalid = 0, resp_ready = 0;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wstrb;
  logic [63:0] mem_wdata, mem_rdata = 0, resp_data;
  logic        resp_valid, resp_we, resp_misalign;
  logic [4:0]  resp_rd;

  int n_chk = 0, n_fail = 0;

  rip_lsu_align dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_rd(resp_rd),
    .resp_we(resp_we), .resp_misalign(resp_misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] maddr; logic [7:0] strb; logic [63:0] wdata; logic mwe;
    int mem_seen; bit mem_unstable;
    logic [63:0] data; logic mis; logic rwe; logic [4:0] rrd;
    int lat; int nresp; bit resp_unstable; bit rr_bad; logic rr_idle;
  } obs_t;

  // ---------------- reference model ----------------
  function automatic bit m_mis(int size, logic [31:0] a);
    return (a % (32'd1 << size)) != 0;
  endfunction

  function automatic logic [7:0] m_strb(int size, logic [31:0] a);
    int nb = 1 << size;
    int v  = ((1 << nb) - 1) << (a % 8);
    return v[7:0];
  endfunction

  function automatic logic [63:0] m_bmask(logic [7:0] s);
    logic [63:0] m = 0;
    for (int i = 0; i < 8; i++) if (s[i]) m = m | (64'hFF << (8 * i));
    return m;
  endfunction

  function automatic logic [63:0] m_load(int size, bit uns, logic [31:0] a, logic [63:0] rd);
    int bits = 8 << size;
    logic [63:0] v = rd >> (8 * (a % 8));
    logic [63:0] lim;
    if (bits == 64) return v;
    lim = (64'd1 << bits) - 1;
    v = v & lim;
    if (!uns && v[bits-1]) v = v | ~lim;
    return v;
  endfunction

  // ---------------- stimulus driver (observes only) ----------------
  task automatic run_access(input logic we, input logic [1:0] size, input logic uns,
                            input logic [31:0] addr, input logic [63:0] wdata,
                            input logic [4:0] rd, input logic [63:0] rdata,
                            input int mstall, input int rstall, output obs_t o);
    int ms = 0, rs = 0, post = -1;
    bit rvn = 0;
    o = '{default: 0};
    req_valid = 1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata; req_rd = rd; mem_rdata = rdata;
    @(posedge clk); #1;
    req_valid = 0;
    for (int c = 1; c <= 60; c++) begin
      mem_rvalid = rvn; rvn = 0; mem_ready = 0; resp_ready = 0;
      if (post < 0 && req_ready) o.rr_bad = 1;
      if (post >= 0 && c == post + 1) o.rr_idle = req_ready;
      if (mem_valid) begin
        if (o.mem_seen == 0) begin
          o.maddr = mem_addr; o.strb = mem_wstrb; o.wdata = mem_wdata; o.mwe = mem_we;
        end else if (mem_addr !== o.maddr || mem_wstrb !== o.strb ||
                     mem_wdata !== o.wdata || mem_we !== o.mwe) o.mem_unstable = 1;
        o.mem_seen++;
        if (ms < mstall) ms++; else begin mem_ready = 1; rvn = 1; end
      end
      if (resp_valid) begin
        if (post >= 0) o.nresp++;
        else begin
          if (o.lat == 0) begin
            o.lat = c; o.data = resp_data; o.mis = resp_misalign; o.rwe = resp_we; o.rrd = resp_rd;
          end else if (resp_data !== o.data || resp_misalign !== o.mis ||
                       resp_we !== o.rwe || resp_rd !== o.rrd) o.resp_unstable = 1;
          if (rs < rstall) rs++; else begin resp_ready = 1; o.nresp++; post = c; end
        end
      end
      if (post >= 0 && c >= post + 3) break;
      @(posedge clk); #1;
    end
    mem_ready = 0; resp_ready = 0; mem_rvalid = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rstn = 0; #12;
    n_chk++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_req_ready got %b want 1", req_ready); end
    n_chk++; if ({mem_valid, resp_valid, mem_we, resp_we, resp_misalign} !== 5'b0) begin
      n_fail++; $display("FAIL rst_ctrl got %b want 00000", {mem_valid, resp_valid, mem_we, resp_we, resp_misalign}); end
    n_chk++; if ({mem_addr, mem_wstrb, mem_wdata, resp_data, resp_rd} !== '0) begin
      n_fail++; $display("FAIL rst_data got %h want 0", {mem_addr, mem_wstrb, mem_wdata, resp_data, resp_rd}); end
    @(posedge clk); #1; rstn = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_lb;
    obs_t o;
    run_access(0, 0, 0, 32'h1003, 64'h0, 5'd7, 64'h0000_0000_8000_0000, 0, 0, o);
    n_chk++; if (o.maddr !== 32'h1000) begin n_fail++; $display("FAIL lb_addr got %h want 00001000", o.maddr); end
    n_chk++; if (o.strb !== 8'h08) begin n_fail++; $display("FAIL lb_strb got %h want 08", o.strb); end
    n_chk++; if (o.data !== 64'hFFFF_FFFF_FFFF_FF80) begin n_fail++; $display("FAIL lb_sext got %h want ffffffffffffff80", o.data); end
    n_chk++; if (o.rrd !== 5'd7 || o.rwe !== 1'b0) begin n_fail++; $display("FAIL lb_tag got rd=%0d we=%b want rd=7 we=0", o.rrd, o.rwe); end
    run_access(0, 0, 1, 32'h1003, 64'h0, 5'd7, 64'h0000_0000_8000_0000, 0, 0, o);
    n_chk++; if (o.data !== 64'h80) begin n_fail++; $display("FAIL lbu_zext got %h want 80", o.data); end
  endtask

  task automatic test_lw_latency;
    obs_t o;
    run_access(0, 2, 0, 32'h2004, 64'h0, 5'd3, 64'h8765_4321_1234_5678, 0, 0, o);
    n_chk++; if (o.data !== 64'hFFFF_FFFF_8765_4321) begin n_fail++; $display("FAIL lw_data got %h want ffffffff87654321", o.data); end
    n_chk++; if (o.lat !== 3) begin n_fail++; $display("FAIL lw_latency got %0d want 3", o.lat); end
    n_chk++; if (o.rr_idle !== 1'b1) begin n_fail++; $display("FAIL lw_ready_back got %b want 1", o.rr_idle); end
  endtask

  task automatic test_sh;
    obs_t o;
    run_access(1, 1, 0, 32'h3006, 64'hABCD, 5'd9, 64'hDEAD_BEEF_DEAD_BEEF, 0, 0, o);
    n_chk++; if (o.mwe !== 1'b1) begin n_fail++; $display("FAIL sh_we got %b want 1", o.mwe); end
    n_chk++; if (o.strb !== 8'hC0) begin n_fail++; $display("FAIL sh_strb got %h want c0", o.strb); end
    n_chk++; if (o.wdata[63:48] !== 16'hABCD) begin n_fail++; $display("FAIL sh_wdata got %h want abcd", o.wdata[63:48]); end
    n_chk++; if (o.rwe !== 1'b1 || o.data !== 64'h0) begin n_fail++; $display("FAIL sh_resp got we=%b data=%h want we=1 data=0", o.rwe, o.data); end
  endtask

  task automatic test_misalign;
    obs_t o;
    run_access(1, 3, 0, 32'h4004, 64'h1122, 5'd1, 64'h0, 0, 0, o);
    n_chk++; if (o.mem_seen !== 0) begin n_fail++; $display("FAIL sd_mis_mem got %0d mem cycles want 0", o.mem_seen); end
    n_chk++; if (o.lat !== 1 || o.mis !== 1'b1) begin n_fail++; $display("FAIL sd_mis_resp got lat=%0d mis=%b want lat=1 mis=1", o.lat, o.mis); end
    n_chk++; if (o.data !== 64'h0) begin n_fail++; $display("FAIL sd_mis_data got %h want 0", o.data); end
    run_access(0, 1, 0, 32'h4001, 64'h0, 5'd2, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, o);
    n_chk++; if (o.mis !== 1'b1 || o.mem_seen !== 0) begin n_fail++; $display("FAIL lh_mis got mis=%b mem=%0d want mis=1 mem=0", o.mis, o.mem_seen); end
    run_access(0, 0, 0, 32'h4001, 64'h0, 5'd2, 64'h0000_0000_0000_7F00, 0, 0, o);
    n_chk++; if (o.mis !== 1'b0 || o.data !== 64'h7F) begin n_fail++; $display("FAIL lb_odd got mis=%b data=%h want mis=0 data=7f", o.mis, o.data); end
  endtask

  task automatic test_backpressure;
    obs_t o;
    run_access(1, 2, 0, 32'h5008, 64'hCAFE_F00D, 5'd12, 64'h0, 3, 2, o);
    n_chk++; if (o.mem_seen !== 4 || o.mem_unstable) begin n_fail++; $display("FAIL bp_mem got cycles=%0d unstable=%b want 4/0", o.mem_seen, o.mem_unstable); end
    n_chk++; if (o.resp_unstable) begin n_fail++; $display("FAIL bp_resp_stable got unstable=%b want 0", o.resp_unstable); end
    n_chk++; if (o.rr_bad) begin n_fail++; $display("FAIL bp_req_ready got high-while-busy=%b want 0", o.rr_bad); end
    n_chk++; if (o.nresp !== 1) begin n_fail++; $display("FAIL bp_nresp got %0d want 1", o.nresp); end
    n_chk++; if (o.lat !== 6) begin n_fail++; $display("FAIL bp_latency got %0d want 6", o.lat); end
  endtask

  task automatic test_reset_wait;
    obs_t o;
    bit stray = 0;
    req_valid = 1; req_we = 0; req_size = 3; req_unsigned = 0; req_addr = 32'h8; req_rd = 5'd4;
    @(posedge clk); #1; req_valid = 0; mem_ready = 1;
    @(posedge clk); #1; mem_ready = 0;
    rstn = 0; #1;
    n_chk++; if (req_ready !== 1'b1 || mem_valid !== 1'b0 || resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL rstw_outputs got rr=%b mv=%b rv=%b want 1 0 0", req_ready, mem_valid, resp_valid); end
    @(posedge clk); #1; rstn = 1;
    @(posedge clk); #1; mem_rvalid = 1; mem_rdata = 64'h5555;
    @(posedge clk); #1; mem_rvalid = 0;
    repeat (3) begin if (resp_valid) stray = 1; @(posedge clk); #1; end
    n_chk++; if (stray) begin n_fail++; $display("FAIL rstw_stray got resp_valid=1 want 0"); end
    run_access(0, 3, 0, 32'h8, 64'h0, 5'd5, 64'h0123_4567_89AB_CDEF, 0, 0, o);
    n_chk++; if (o.data !== 64'h0123_4567_89AB_CDEF || o.maddr !== 32'h8) begin
      n_fail++; $display("FAIL rstw_ld got data=%h addr=%h want 0123456789abcdef 00000008", o.data, o.maddr); end
  endtask

  task automatic test_random;
    obs_t o;
    for (int i = 0; i < 40; i++) begin
      logic we, uns; logic [1:0] sz; logic [31:0] a; logic [63:0] wd, rdat; logic [4:0] rd;
      int ms, rs; bit mis; logic [7:0] es; logic [63:0] ed, bm;
      we = $urandom_range(0, 1); uns = $urandom_range(0, 1); sz = 2'($urandom_range(0, 3));
      a = 32'h100 + $urandom_range(0, 255); rd = 5'($urandom);
      wd = {$urandom, $urandom}; rdat = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 1);
      ms = $urandom_range(0, 2); rs = $urandom_range(0, 2);
      run_access(we, sz, uns, a, wd, rd, rdat, ms, rs, o);
      mis = m_mis(sz, a);
      es  = m_strb(sz, a);
      bm  = m_bmask(es);
      ed  = (mis || we) ? 64'h0 : m_load(sz, uns, a, rdat);
      n_chk++; if (o.nresp !== 1 || o.mis !== mis || o.rwe !== we || o.rrd !== rd) begin
        n_fail++; $display("FAIL rnd%0d_resp got n=%0d mis=%b we=%b rd=%0d want 1 %b %b %0d", i, o.nresp, o.mis, o.rwe, o.rrd, mis, we, rd); end
      n_chk++; if (o.data !== ed) begin n_fail++; $display("FAIL rnd%0d_data got %h want %h", i, o.data, ed); end
      n_chk++; if (o.lat !== (mis ? 1 : 3 + ms)) begin n_fail++; $display("FAIL rnd%0d_lat got %0d want %0d", i, o.lat, mis ? 1 : 3 + ms); end
      if (mis) begin
        n_chk++; if (o.mem_seen !== 0) begin n_fail++; $display("FAIL rnd%0d_mem got %0d cycles want 0", i, o.mem_seen); end
      end else begin
        n_chk++; if (o.mem_seen !== ms + 1 || o.maddr !== {a[31:3], 3'b000} || o.strb !== es || o.mwe !== we ||
                     (o.wdata & bm) !== ((wd << (8 * (a % 8))) & bm)) begin
          n_fail++; $display("FAIL rnd%0d_mem got n=%0d a=%h s=%h we=%b wd=%h want n=%0d a=%h s=%h we=%b wd=%h", i,
            o.mem_seen, o.maddr, o.strb, o.mwe, o.wdata & bm, ms + 1, {a[31:3], 3'b000}, es, we, (wd << (8 * (a % 8))) & bm); end
      end
    end
  endtask

  initial begin
    test_reset;
    test_lb;
    test_lw_latency;
    test_sh;
    test_misalign;
    test_backpressure;
    test_reset_wait;
    test_random;
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/rip_lsu_align.md
Name: rip_lsu_align

Overview:
- Load/store access stage between the execute stage and the data-memory port of the RIP core.
- Takes one byte, half, word or double-word access request at a time. Drives it onto a 64-bit doubleword-addressed memory bus with byte strobes.
- Aligns returned load data, then sign- or zero-extends it to D_WIDTH for writeback.
- Access widths come from the package constants B_WIDTH/H_WIDTH/W_WIDTH/D_WIDTH (8/16/32/64).

Parameters:
- ADDR_WIDTH, 32, byte-address width of req_addr/mem_addr.
- RD_WIDTH, 5, destination register index width.

Ports:
- clk  in  1  core clock, all state on rising edge.
- rstn  in  1  asynchronous active-low reset.
- req_valid  in  1  execute stage presents an access.
- req_ready  out  1  block can accept an access.
- req_we  in  1  1=store, 0=load.
- req_size  in  2  0=byte, 1=half, 2=word, 3=double.
- req_unsigned  in  1  zero-extend load (LBU/LHU/LWU); ignored for stores and for size 3.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  D_WIDTH  store data, right-justified.
- req_rd  in  RD_WIDTH  destination register tag.
- mem_valid  out  1  memory request.
- mem_ready  in  1  memory accepts request.
- mem_we  out  1  write enable.
- mem_addr  out  ADDR_WIDTH  req_addr with bits [2:0] forced to 0.
- mem_wstrb  out  D_WIDTH/B_WIDTH  byte strobes (8 bits).
- mem_wdata  out  D_WIDTH  store data shifted left by addr[2:0]*8.
- mem_rvalid  in  1  memory response (load data or store ack).
- mem_rdata  in  D_WIDTH  doubleword read data.
- resp_valid  out  1  result available.
- resp_ready  in  1  writeback consumes result.
- resp_data  out  D_WIDTH  extended load data; 0 for stores and faults.
- resp_rd  out  RD_WIDTH  registered req_rd.
- resp_we  out  1  registered req_we.
- resp_misalign  out  1  access was misaligned; no memory transaction was issued.

Behaviour:
- Reset (rstn=0, async): state=IDLE. All outputs 0 except req_ready=1. Reset mid-transaction abandons the memory access; a later stray mem_rvalid is ignored.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - req_ready=1. On req_valid, register we/size/unsigned/addr/wdata/rd.
  - Misaligned means (size=1 & addr[0]) | (size=2 & addr[1:0]!=0) | (size=3 & addr[2:0]!=0). Misaligned -> RESP with resp_misalign=1 and resp_data=0; no mem_valid ever. Aligned -> REQ.
- REQ:
  - mem_valid=1; mem_addr/we/wstrb/wdata held stable until mem_ready.
  - mem_wstrb = size mask (0x01/0x03/0x0F/0xFF) << addr[2:0]. Strobes are driven for loads too.
  - mem_wdata = req_wdata << (addr[2:0]*8); bits outside the strobes are don't-care but must be deterministic.
  - mem_valid&mem_ready -> WAIT. mem_rvalid in the same cycle as the accept is not a legal response and is ignored.
- WAIT:
  - mem_valid=0. On mem_rvalid:
    - Load: shift mem_rdata right by addr[2:0]*8, keep the low (8<<size) bits. Sign-extend from the top kept bit unless req_unsigned.
    - Store: resp_data=0.
  - Either case -> RESP.
  - mem_rvalid outside WAIT is ignored.
- RESP:
  - resp_valid=1; resp_* held stable until resp_ready. resp_valid&resp_ready -> IDLE.
  - req_ready=0 in REQ/WAIT/RESP. No acceptance in the same cycle as the response handshake (one access in flight).
- Latency, aligned access with zero-wait memory: accept at edge N, mem_valid cycle N+1, mem_rvalid cycle N+2, resp_valid cycle N+3.
- Latency, misaligned access: resp_valid cycle N+1.
- resp_valid and mem_valid are registered outputs, never combinational from inputs. req_ready is decoded from state only.

Test Plan:
- LB addr=0x1003, mem_rdata=0x0000_0000_8000_0000 -> mem_addr=0x1000, mem_wstrb=0x08, resp_data=0xFFFF_FFFF_FFFF_FF80. Same with req_unsigned=1 -> 0x80.
- LW addr=0x2004, mem_rdata=0x8765_4321_1234_5678 -> resp_data=0xFFFF_FFFF_8765_4321. Latency exactly 3 cycles from accept to resp_valid with mem_ready=1 and next-cycle rvalid.
- SH addr=0x3006, wdata=0xABCD -> mem_we=1, mem_wstrb=0xC0, mem_wdata[63:48]=0xABCD; on ack resp_we=1, resp_data=0.
- SD addr=0x4004 -> no mem_valid. resp_valid next cycle with resp_misalign=1. LH addr=0x4001 also faults; LB addr=0x4001 does not.
- Backpressure: mem_ready low 3 cycles, then resp_ready low 2 cycles -> mem_* and resp_* stable throughout, req_ready=0 throughout, exactly one response.
- Assert rstn low during WAIT, release, pulse mem_rvalid -> no resp_valid. Next LD addr=0x8 with rdata=0x0123_4567_89AB_CDEF returns that value unchanged.
